// File: rtl/exc_ctrl_if.sv
// Writeback-to-CP0/fetch bundle of the exception commit controller.
// EXC_IRQ_EN adds the int_pending request line.
interface exc_ctrl_if;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [6:0]  wb_exc_flags;
    logic        wb_eret;
    logic        status_exl;
    logic [31:0] epc;
`ifdef EXC_IRQ_EN
    logic        int_pending;
`endif
    logic        execption;
    logic [4:0]  ExcCode;
    logic [31:0] execption_pc;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_ready;
    logic        busy;

`ifdef EXC_IRQ_EN
    modport master (
        output wb_valid, wb_pc, wb_exc_flags, wb_eret, status_exl, epc, int_pending, fetch_ready,
        input  execption, ExcCode, execption_pc, flush, redirect_valid, redirect_pc, busy
    );
    modport slave (
        input  wb_valid, wb_pc, wb_exc_flags, wb_eret, status_exl, epc, int_pending, fetch_ready,
        output execption, ExcCode, execption_pc, flush, redirect_valid, redirect_pc, busy
    );
`else
    modport master (
        output wb_valid, wb_pc, wb_exc_flags, wb_eret, status_exl, epc, fetch_ready,
        input  execption, ExcCode, execption_pc, flush, redirect_valid, redirect_pc, busy
    );
    modport slave (
        input  wb_valid, wb_pc, wb_exc_flags, wb_eret, status_exl, epc, fetch_ready,
        output execption, ExcCode, execption_pc, flush, redirect_valid, redirect_pc, busy
    );
`endif
endinterface

// File: rtl/exc_ctrl.sv
// Exception/ERET commit controller: prioritises flags, strobes CP0, flushes, redirects fetch.
// Optional interrupt entry (ExcCode 0) enabled by defining EXC_IRQ_EN.
module exc_ctrl #(
    parameter logic [31:0] VECTOR       = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] target_q;
    logic        exc_q;
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic        flush_q;
    logic        rv_q;

    logic [4:0]  flag_code;
    logic        exc_take;
    logic        eret_take;
    logic        irq_take;

    function automatic logic [4:0] code_of(input int idx);
        case (idx)
            0:       return 5'd4;
            1:       return 5'd10;
            2:       return 5'd12;
            3:       return 5'd8;
            4:       return 5'd9;
            5:       return 5'd4;
            default: return 5'd5;
        endcase
    endfunction

    // Scan from the top so the lowest set flag wins.
    always_comb begin
        flag_code = 5'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bus.wb_exc_flags[i]) flag_code = code_of(i);
        end
    end

    assign exc_take  = bus.wb_valid && (bus.wb_exc_flags != 7'd0);
    assign eret_take = bus.wb_valid && bus.wb_eret && (bus.wb_exc_flags == 7'd0);
`ifdef EXC_IRQ_EN
    assign irq_take  = bus.wb_valid && bus.int_pending && !bus.status_exl;
`else
    assign irq_take  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            target_q <= 32'd0;
            exc_q    <= 1'b0;
            code_q   <= 5'd0;
            pc_q     <= 32'd0;
            flush_q  <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            exc_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (irq_take || exc_take) begin
                        code_q   <= irq_take ? 5'd0 : flag_code;
                        pc_q     <= bus.wb_pc;
                        // With EXL set CP0 must keep its EPC, so no strobe.
                        exc_q    <= !bus.status_exl;
                        target_q <= VECTOR;
                        flush_q  <= 1'b1;
                        cnt_q    <= 4'(FLUSH_CYCLES);
                        state_q  <= StFlush;
                    end else if (eret_take) begin
                        target_q <= bus.epc;
                        flush_q  <= 1'b1;
                        cnt_q    <= 4'(FLUSH_CYCLES);
                        state_q  <= StFlush;
                    end
                end
                StFlush: begin
                    if (cnt_q == 4'd1) begin
                        flush_q <= 1'b0;
                        rv_q    <= 1'b1;
                        state_q <= StRedirect;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRedirect: begin
                    if (bus.fetch_ready) begin
                        rv_q    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.execption      = exc_q;
    assign bus.ExcCode        = code_q;
    assign bus.execption_pc   = pc_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = target_q;
    assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: driver+model push expected events, negedge monitor checks them.
module tb_exc_ctrl;
    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int          FC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exc_ctrl_if bus ();

    exc_ctrl #(.VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          strobe;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] target;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cnt = 0;
    bit   m_redir = 1'b0;
    bit   exp_busy = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_code(input logic [6:0] f);
        int codes[7] = '{4, 10, 12, 8, 9, 4, 5};
        for (int i = 0; i < 7; i++) if (f[i]) return codes[i];
        return -1;
    endfunction

    // Reference timeline: accept only when free; busy for FC flush cycles plus the redirect wait.
    task automatic model_edge();
        exp_t e;
        bit   take;
        take = 1'b0;
        e = '{strobe: 1'b0, code: 5'd0, pc: 32'd0, target: 32'd0};
        if (rst) begin
            m_cnt = 0;
            m_redir = 1'b0;
            exp_q.delete();
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_redir = 1'b1;
        end else if (m_redir) begin
            if (bus.fetch_ready) m_redir = 1'b0;
        end else if (bus.wb_valid) begin
`ifdef EXC_IRQ_EN
            if (bus.int_pending && !bus.status_exl) begin
                e = '{strobe: 1'b1, code: 5'd0, pc: bus.wb_pc, target: VEC};
                take = 1'b1;
            end
`endif
            if (!take && bus.wb_exc_flags != 7'd0) begin
                e = '{strobe: !bus.status_exl, code: 5'(ref_code(bus.wb_exc_flags)),
                      pc: bus.wb_pc, target: VEC};
                take = 1'b1;
            end else if (!take && bus.wb_eret) begin
                e = '{strobe: 1'b0, code: 5'd0, pc: 32'd0, target: bus.epc};
                take = 1'b1;
            end
            if (take) begin
                exp_q.push_back(e);
                m_cnt = FC;
            end
        end
        exp_busy = (m_cnt != 0) || m_redir;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        bus.wb_valid     = 1'b0;
        bus.wb_pc        = 32'd0;
        bus.wb_exc_flags = 7'd0;
        bus.wb_eret      = 1'b0;
        bus.status_exl   = 1'b0;
        bus.epc          = 32'd0;
`ifdef EXC_IRQ_EN
        bus.int_pending  = 1'b0;
`endif
    endtask

    task automatic tx(input logic [31:0] pc, input logic [6:0] f, input bit eret, input bit exl,
                      input logic [31:0] epcv);
        bus.wb_valid     = 1'b1;
        bus.wb_pc        = pc;
        bus.wb_exc_flags = f;
        bus.wb_eret      = eret;
        bus.status_exl   = exl;
        bus.epc          = epcv;
        step();
        set_idle();
    endtask

    task automatic drain(input int stall);
        bus.fetch_ready = 1'b0;
        repeat (stall) step();
        bus.fetch_ready = 1'b1;
        for (int i = 0; i < 50 && exp_busy; i++) step();
        step();
    endtask

    // Monitor: pops an expectation on each flush rising edge, then follows flush and redirect.
    initial begin
        bit   prev_flush;
        bit   in_redir;
        bit   hs;
        bit   rise;
        int   fcnt;
        exp_t cur;
        prev_flush = 1'b0;
        in_redir = 1'b0;
        hs = 1'b0;
        fcnt = 0;
        cur = '{strobe: 1'b0, code: 5'd0, pc: 32'd0, target: 32'd0};
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_flush = 1'b0;
                in_redir = 1'b0;
                hs = 1'b0;
                fcnt = 0;
            end else begin
                check("busy", bus.busy, exp_busy);
                rise = bus.flush && !prev_flush;
                if (rise) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_flush: got flush=1, want 0 (t=%0t)", $time);
                    end else begin
                        cur = exp_q.pop_front();
                        check("strobe", bus.execption, cur.strobe);
                        if (cur.strobe) begin
                            check("exc_code", bus.ExcCode, cur.code);
                            check("exc_pc", bus.execption_pc, cur.pc);
                        end
                    end
                    fcnt = 1;
                end else if (bus.flush) begin
                    fcnt++;
                end else if (prev_flush) begin
                    check("flush_len", fcnt, FC);
                    in_redir = 1'b1;
                end
                if (bus.execption && !rise) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_strobe: got execption=1, want 0 (t=%0t)", $time);
                end
                if (in_redir) begin
                    if (hs) begin
                        check("redir_drop", bus.redirect_valid, 0);
                        in_redir = 1'b0;
                        hs = 1'b0;
                    end else begin
                        check("redir_valid", bus.redirect_valid, 1);
                        check("redir_pc", bus.redirect_pc, cur.target);
                        hs = bus.fetch_ready;
                    end
                end
                prev_flush = bus.flush;
            end
        end
    end

    initial begin
        set_idle();
        bus.fetch_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        check("rst_exc", bus.execption, 0);
        check("rst_code", bus.ExcCode, 0);
        check("rst_pc", bus.execption_pc, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_rv", bus.redirect_valid, 0);
        check("rst_rpc", bus.redirect_pc, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        // Ov with backpressure and a second flagged instruction arriving while busy.
        bus.fetch_ready = 1'b0;
        tx(32'h80001000, 7'b0000100, 1'b0, 1'b0, 32'd0);
        tx(32'h80001004, 7'b0001000, 1'b0, 1'b0, 32'd0);
        drain(7);
        tx(32'h80001100, 7'b1000010, 1'b0, 1'b0, 32'd0);
        drain(0);
        tx(32'h80001200, 7'b1000000, 1'b1, 1'b0, 32'd0);
        drain(1);
        tx(32'h80001300, 7'b0000000, 1'b1, 1'b0, 32'h80002004);
        drain(2);
        tx(32'h80001400, 7'b0001000, 1'b0, 1'b1, 32'd0);
        drain(0);
        // wb_valid low: everything ignored.
        bus.wb_exc_flags = 7'h7f;
        bus.wb_eret = 1'b1;
        step();
        set_idle();
        drain(0);
`ifdef EXC_IRQ_EN
        bus.int_pending = 1'b1;
        tx(32'h80001500, 7'b0000100, 1'b0, 1'b0, 32'd0);
        drain(0);
        bus.int_pending = 1'b1;
        tx(32'h80001600, 7'b0000000, 1'b0, 1'b1, 32'd0);
        drain(0);
`endif

        // Reset while in FLUSH.
        tx(32'h80001700, 7'b0000100, 1'b0, 1'b0, 32'd0);
        step();
        mon_en = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_exc", bus.execption, 0);
        check("mid_rst_code", bus.ExcCode, 0);
        check("mid_rst_pc", bus.execption_pc, 0);
        check("mid_rst_flush", bus.flush, 0);
        check("mid_rst_rv", bus.redirect_valid, 0);
        check("mid_rst_rpc", bus.redirect_pc, 0);
        check("mid_rst_busy", bus.busy, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        for (int c = 0; c < 3000; c++) begin
            int r;
            bus.wb_valid = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 3));
            if (r == 0) bus.wb_exc_flags = 7'd0;
            else if (r == 1) bus.wb_exc_flags = 7'(1 << $urandom_range(0, 6));
            else bus.wb_exc_flags = 7'($urandom);
            bus.wb_eret = ($urandom % 3) == 0;
            bus.status_exl = ($urandom % 4) == 0;
            bus.wb_pc = $urandom;
            bus.epc = $urandom;
`ifdef EXC_IRQ_EN
            bus.int_pending = ($urandom % 5) == 0;
`endif
            bus.fetch_ready = ($urandom % 3) != 0;
            step();
        end

        set_idle();
        bus.fetch_ready = 1'b1;
        repeat (20) step();
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/ERET commit controller in the writeback stage, directly upstream of the CP0 register file.
- Prioritises per-instruction exception flags, emits the one-cycle exception strobe, ExcCode and faulting PC that CP0 consumes, flushes the pipeline and redirects fetch to the handler vector.
- On ERET, redirects fetch to the EPC value that CP0 holds.

Parameters:
VECTOR  32'hBFC00380  exception handler entry address
FLUSH_CYCLES  2  cycles flush is held; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wb_valid  in  1  valid instruction in commit slot
wb_pc  in  32  PC of commit-slot instruction
wb_exc_flags  in  7  [0] fetch AdEL, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] data AdEL, [6] data AdES
wb_eret  in  1  commit-slot instruction is ERET
status_exl  in  1  CP0 SR.EXL
epc  in  32  CP0 EPC
execption  out  1  one-cycle strobe to CP0
ExcCode  out  5  cause code to CP0
execption_pc  out  32  faulting PC to CP0
flush  out  1  kill all pipeline stages
redirect_valid  out  1  fetch redirect request
redirect_pc  out  32  redirect target
fetch_ready  in  1  fetch accepts redirect this cycle
busy  out  1  state != IDLE

Behaviour:
- Single clock clk; rst is synchronous and active-high.
- Reset: state IDLE; all outputs 0, including ExcCode, execption_pc and redirect_pc.
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE, sampled at edge T:
  - Trigger when wb_valid=1 and wb_exc_flags!=0.
  - Priority is lowest set bit. Codes: bit0→4, 1→10, 2→12, 3→8, 4→9, 5→4, 6→5.
  - At T+1:
    - ExcCode and execption_pc=wb_pc are registered.
    - execption=1 for exactly one cycle, only if status_exl was 0 at T. With EXL=1 there is no strobe, so EPC is preserved.
    - flush=1, target latched as VECTOR, state=FLUSH.
- ERET in IDLE: wb_valid=1, wb_eret=1 and flags==0. No strobe; target latched as epc sampled at T; flush=1 from T+1; state=FLUSH.
- Flags and wb_eret both set: exception wins and ERET is ignored.
- wb_valid=0: flags and eret are ignored.
- FLUSH:
  - flush held high exactly FLUSH_CYCLES cycles, counting from T+1.
  - Then state=REDIRECT and flush drops.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=latched target, held stable until fetch_ready=1.
  - On the cycle fetch_ready=1, transfer completes. Next cycle: redirect_valid=0, state=IDLE.
  - fetch_ready=1 on the first REDIRECT cycle gives a one-cycle redirect.
- While busy, all wb_* inputs are ignored. No new strobe is issued until back in IDLE.
- Minimum turnaround from trigger to next acceptable trigger: FLUSH_CYCLES+2 cycles.
- rst mid-operation (any state) returns to IDLE, clears outputs and abandons the pending redirect.
- ExcCode and execption_pc hold their last values between strobes. They are meaningful only when execption=1.

Optional Feature:
- Macro: EXC_IRQ_EN.
- Defined:
  - Adds input int_pending (1 bit).
  - In IDLE, wb_valid=1 and int_pending=1 and status_exl=0 triggers an interrupt. The interrupt has priority over all flags.
  - Result: ExcCode=0, execption_pc=wb_pc, redirect to VECTOR, with the same flush/redirect sequence.
  - int_pending with status_exl=1 is ignored.
- Not defined: the int_pending port is absent and ExcCode 0 is never produced.

Test Plan:
- Ov: wb_valid=1, flags=7'b0000100, wb_pc=0x80001000, exl=0 → next cycle execption=1 for 1 cycle, ExcCode=12, execption_pc=0x80001000; flush high 2 cycles; redirect_valid with redirect_pc=0xBFC00380 until fetch_ready.
- Priority: flags=7'b1000010 → ExcCode=10 (RI). Flags=7'b1000000 → ExcCode=5.
- ERET: wb_eret=1, flags=0, epc=0x80002004 → no execption; flush 2 cycles; redirect_pc=0x80002004.
- Nested: exl=1, flags=Sys → execption stays 0; flush and redirect to 0xBFC00380 still occur.
- Backpressure and busy: fetch_ready=0 for 5 cycles → redirect_valid and redirect_pc stable. A second flagged instruction while busy is ignored (no second strobe).
- Reset in FLUSH → next cycle all outputs 0, busy=0. Without EXC_IRQ_EN, int_pending is absent. With EXC_IRQ_EN, int_pending=1 plus Ov flag → ExcCode=0.
